// File: rtl/draw_playfield_pkg.sv
// Shared types for the playfield renderer: colour encoding and flash FSM states.
package draw_playfield_pkg;

  typedef logic [3:0] color_t;

  localparam color_t C_EMPTY  = 4'b0000;
  localparam color_t C_BORDER = 4'b0110;
  localparam color_t C_FLASH  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } flash_state_t;

  // Piece ids map onto the upper half of the palette; id 0 is an empty cell.
  function automatic color_t piece_color(input logic [2:0] id);
    color_t c;
    if (id == 3'd0) begin
      c = C_EMPTY;
    end else begin
      c = {1'b1, id};
    end
    return c;
  endfunction

endpackage

// File: rtl/draw_playfield_flash_ctrl.sv
// Line-clear flash sequencer: latches the row mask on a request and alternates
// ON/OFF phases, counting frames, until the configured number of phases has elapsed.
module playfield_flash_ctrl
  import draw_playfield_pkg::*;
#(
  parameter int ROWS          = 22,
  parameter int FLASH_FRAMES  = 8,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            frame_start_i,
  input  logic            clear_req_i,
  input  logic [ROWS-1:0] clear_mask_i,
  output logic            busy_o,
  output logic            clear_done_o,
  output logic            flash_on_o,
  output logic            flash_off_o,
  output logic [ROWS-1:0] mask_o
);

  localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int PW = $clog2(FLASH_TOGGLES + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FLASH_FRAMES - 1);
  localparam logic [PW-1:0] PHASE_END  = PW'(FLASH_TOGGLES);

  flash_state_t    state_q, state_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [PW-1:0]   phase_inc_s;
  logic [ROWS-1:0] mask_q, mask_d;

  assign phase_inc_s = phase_q + PW'(1);

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    phase_d = phase_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        // A frame_start coinciding with the request is deliberately not counted.
        if (clear_req_i) begin
          mask_d  = clear_mask_i;
          frame_d = '0;
          phase_d = '0;
          state_d = ON;
        end else begin
          state_d = IDLE;
        end
      end
      ON, OFF: begin
        if (frame_start_i) begin
          if (frame_q == FRAME_LAST) begin
            frame_d = '0;
            phase_d = phase_inc_s;
            if (phase_inc_s == PHASE_END) begin
              state_d = DONE;
            end else if (state_q == ON) begin
              state_d = OFF;
            end else begin
              state_d = ON;
            end
          end else begin
            frame_d = frame_q + FW'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      DONE: begin
        mask_d  = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      phase_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      mask_q  <= mask_d;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign clear_done_o = (state_q == DONE);
  assign flash_on_o   = (state_q == ON);
  assign flash_off_o  = (state_q == OFF);
  assign mask_o       = mask_q;

endmodule

// File: rtl/draw_playfield.sv
// Playfield renderer: two-stage pixel pipeline mapping (x, y) to a colour and
// draw-enable for the field and its border, with line-clear flashing.
module draw_playfield
  import draw_playfield_pkg::*;
#(
  parameter int COLS          = 10,
  parameter int ROWS          = 22,
  parameter int VIS_ROWS      = 20,
  parameter int ID_W          = 3,
  parameter int BLOCK_PX      = 16,
  parameter int START_X       = 240,
  parameter int START_Y       = 80,
  parameter int BORDER_PX     = 4,
  parameter int FLASH_FRAMES  = 8,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [ROWS-1:0][COLS-1:0][ID_W-1:0]  cells,
  input  logic [10:0]                          x,
  input  logic [10:0]                          y,
  input  logic                                 frame_start,
  input  logic [ROWS-1:0]                      clear_mask,
  input  logic                                 clear_req,
  output logic                                 busy,
  output logic                                 clear_done,
  output color_t                               color,
  output logic                                 drawEnable
);

  localparam int SH = $clog2(BLOCK_PX);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [10:0] FX0 = 11'(START_X);
  localparam logic [10:0] FY0 = 11'(START_Y);
  localparam logic [10:0] FX1 = 11'(START_X + COLS * BLOCK_PX);
  localparam logic [10:0] FY1 = 11'(START_Y + VIS_ROWS * BLOCK_PX);
  localparam logic [10:0] BX0 = 11'(START_X - BORDER_PX);
  localparam logic [10:0] BY0 = 11'(START_Y - BORDER_PX);
  localparam logic [10:0] BX1 = 11'(START_X + COLS * BLOCK_PX + BORDER_PX);
  localparam logic [10:0] BY1 = 11'(START_Y + VIS_ROWS * BLOCK_PX + BORDER_PX);
  localparam logic [10:0] ROW_OFS = 11'(ROWS - VIS_ROWS);

  if ((BLOCK_PX < 4) || ((BLOCK_PX & (BLOCK_PX - 1)) != 0)) begin : g_bad_block
    $error("BLOCK_PX must be a power of two and at least 4");
  end
  if (VIS_ROWS > ROWS) begin : g_bad_rows
    $error("VIS_ROWS must not exceed ROWS");
  end
  if ((FLASH_TOGGLES % 2) != 0) begin : g_bad_toggles
    $error("FLASH_TOGGLES must be even");
  end
  if (ID_W != 3) begin : g_bad_id
    $error("ID_W must be 3 to fit the colour encoding");
  end

  logic            flash_on_s, flash_off_s;
  logic [ROWS-1:0] mask_s;

  playfield_flash_ctrl #(
    .ROWS          (ROWS),
    .FLASH_FRAMES  (FLASH_FRAMES),
    .FLASH_TOGGLES (FLASH_TOGGLES)
  ) u_flash_ctrl (
    .clk           (clk),
    .reset         (reset),
    .frame_start_i (frame_start),
    .clear_req_i   (clear_req),
    .clear_mask_i  (clear_mask),
    .busy_o        (busy),
    .clear_done_o  (clear_done),
    .flash_on_o    (flash_on_s),
    .flash_off_o   (flash_off_s),
    .mask_o        (mask_s)
  );

  logic [10:0]   dx_s, dy_s;
  logic          in_box_d, in_field_d, gap_d;
  logic [CW-1:0] col_d;
  logic [RW-1:0] row_d;
  logic          in_box_q, in_field_q, gap_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  color_t        color_d, color_q;
  logic          draw_en_q;
  logic [ID_W-1:0] id_s;

  // Offsets wrap when the pixel is left of/above the field; in_field masks that.
  always_comb begin
    dx_s       = x - FX0;
    dy_s       = y - FY0;
    in_box_d   = (x >= BX0) && (x < BX1) && (y >= BY0) && (y < BY1);
    in_field_d = (x >= FX0) && (x < FX1) && (y >= FY0) && (y < FY1);
    col_d      = CW'(dx_s >> SH);
    row_d      = RW'((dy_s >> SH) + ROW_OFS);
    gap_d      = (dx_s[SH-1:0] == '0) || (dx_s[SH-1:0] == '1) ||
                 (dy_s[SH-1:0] == '0) || (dy_s[SH-1:0] == '1);
  end

  always_comb begin
    id_s    = cells[row_q][col_q];
    color_d = C_EMPTY;
    if (in_box_q && !in_field_q) begin
      color_d = C_BORDER;
    end else if (!in_box_q) begin
      color_d = C_EMPTY;
    end else if (gap_q) begin
      color_d = C_EMPTY;
    end else if (mask_s[row_q] && flash_on_s) begin
      color_d = C_FLASH;
    end else if (mask_s[row_q] && flash_off_s) begin
      color_d = C_EMPTY;
    end else begin
      color_d = piece_color(id_s);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_box_q   <= 1'b0;
      in_field_q <= 1'b0;
      gap_q      <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      color_q    <= C_EMPTY;
      draw_en_q  <= 1'b0;
    end else begin
      in_box_q   <= in_box_d;
      in_field_q <= in_field_d;
      gap_q      <= gap_d;
      col_q      <= col_d;
      row_q      <= row_d;
      color_q    <= color_d;
      draw_en_q  <= in_box_q;
    end
  end

  assign color      = color_q;
  assign drawEnable = draw_en_q;

endmodule
